// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and reset constants for the unified-memory
// port arbiter (mem_port_arbiter and its round-robin picker rr_arb2).
package mem_arb_pkg;

  // Arbiter FSM encoding; the top module mirrors these as logic constants.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  // Which requester owns (or last owned) the memory port.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // Reset constants: fetch must win the first tie, so the picker starts
  // believing data was served last.
  localparam logic [1:0] RST_STATE      = 2'd0;
  localparam grant_e     RST_LAST_GRANT = GRANT_D;

  // Map a grant decision onto the FSM state that serves it.
  function automatic logic [1:0] grant_state(input grant_e g);
    logic [1:0] st;
    case (g)
      GRANT_I: st = 2'd1;
      GRANT_D: st = 2'd2;
      default: st = 2'd0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side handshake bundle.
// The slave modport is the arbiter's view; master is the surrounding
// core + memory macro.
interface mem_port_arbiter_if #(
  parameter int DWidth = 32
);

  // instruction-fetch requester
  logic              imem_req_i;
  logic [DWidth-1:0] imem_addr_i;
  logic              imem_ready_o;
  logic [DWidth-1:0] imem_rdata_o;

  // load/store requester
  logic              dmem_req_i;
  logic              dmem_write_i;
  logic [DWidth-1:0] dmem_addr_i;
  logic [DWidth-1:0] dmem_wdata_i;
  logic              dmem_ready_o;
  logic [DWidth-1:0] dmem_rdata_o;

  // single memory port
  logic              mem_req_o;
  logic              mem_write_o;
  logic [DWidth-1:0] mem_addr_o;
  logic [DWidth-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DWidth-1:0] mem_rdata_i;

  modport slave (
    input  imem_req_i, imem_addr_i,
    input  dmem_req_i, dmem_write_i, dmem_addr_i, dmem_wdata_i,
    input  mem_ready_i, mem_rdata_i,
    output imem_ready_o, imem_rdata_o,
    output dmem_ready_o, dmem_rdata_o,
    output mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output imem_req_i, imem_addr_i,
    output dmem_req_i, dmem_write_i, dmem_addr_i, dmem_wdata_i,
    output mem_ready_i, mem_rdata_i,
    input  imem_ready_o, imem_rdata_o,
    input  dmem_ready_o, dmem_rdata_o,
    input  mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin picker. The pick is purely
// combinational; only the last winner is stored, and it moves only when
// the owner of the grant strobe says a grant was actually taken.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_fetch,
  input  logic   req_data,
  input  logic   grant_stb,
  output grant_e pick
);

  grant_e last_grant_r;
  grant_e pick_s;

  // choose a winner: a lone requester wins outright, a tie goes to the
  // requester that did not win last time
  always_comb begin
    pick_s = GRANT_I;
    if (req_fetch && req_data) begin
      if (last_grant_r == GRANT_I) begin
        pick_s = GRANT_D;
      end else begin
        pick_s = GRANT_I;
      end
    end else if (req_data) begin
      pick_s = GRANT_D;
    end else begin
      pick_s = GRANT_I;
    end
  end

  // remember the winner at the grant edge
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= RST_LAST_GRANT;
    end else if (grant_stb) begin
      last_grant_r <= pick_s;
    end
  end

  assign pick = pick_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction
// fetch and load/store. A grant latches the winner's access into the
// mem_* registers, which stay frozen until the memory answers; the answer
// is steered back to the winner combinationally in the same cycle.
// Optional statistics counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DWidth    = 32,
  parameter int StatWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef MEM_ARB_STATS_EN
  output logic [StatWidth-1:0] stat_igrant_o,
  output logic [StatWidth-1:0] stat_dgrant_o,
  output logic [StatWidth-1:0] stat_conflict_o,
`endif
  mem_port_arbiter_if.slave    bus
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_GNT_I = GNT_I;
  localparam logic [1:0] ST_GNT_D = GNT_D;

  // reject parameter values that cannot build
  if (DWidth < 1 || StatWidth < 1) begin : g_param_check
    $error("mem_port_arbiter: DWidth and StatWidth must be positive");
  end

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              mem_req_r;
  logic              mem_req_nxt_s;
  logic              mem_write_r;
  logic              mem_write_nxt_s;
  logic [DWidth-1:0] mem_addr_r;
  logic [DWidth-1:0] mem_addr_nxt_s;
  logic [DWidth-1:0] mem_wdata_r;
  logic [DWidth-1:0] mem_wdata_nxt_s;

  logic              grant_stb_s;
  grant_e            pick_s;
  logic              imem_ready_s;
  logic              dmem_ready_s;

  // A grant can only be taken from IDLE; requests seen while a transfer
  // is in flight wait for the next IDLE cycle.
  assign grant_stb_s = (state_r == ST_IDLE) && (bus.imem_req_i || bus.dmem_req_i);

  rr_arb2 u_rr_arb2 (
    .clk       (clk_i),
    .rst       (rst_i),
    .req_fetch (bus.imem_req_i),
    .req_data  (bus.dmem_req_i),
    .grant_stb (grant_stb_s),
    .pick      (pick_s)
  );

  // next-state and memory-port register values
  always_comb begin
    state_nxt_s     = state_r;
    mem_req_nxt_s   = mem_req_r;
    mem_write_nxt_s = mem_write_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_stb_s) begin
          state_nxt_s   = grant_state(pick_s);
          mem_req_nxt_s = 1'b1;
          if (pick_s == GRANT_I) begin
            // fetches are always reads and carry no write data
            mem_write_nxt_s = 1'b0;
            mem_addr_nxt_s  = bus.imem_addr_i;
            mem_wdata_nxt_s = '0;
          end else begin
            mem_write_nxt_s = bus.dmem_write_i;
            mem_addr_nxt_s  = bus.dmem_addr_i;
            mem_wdata_nxt_s = bus.dmem_wdata_i;
          end
        end else begin
          mem_req_nxt_s = 1'b0;
        end
      end
      ST_GNT_I, ST_GNT_D: begin
        // requester inputs are deliberately not looked at here
        if (bus.mem_ready_i) begin
          state_nxt_s   = ST_IDLE;
          mem_req_nxt_s = 1'b0;
        end else begin
          mem_req_nxt_s = 1'b1;
        end
      end
      default: begin
        // unreachable encoding: fall back to a quiet port
        state_nxt_s   = ST_IDLE;
        mem_req_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM and memory-port output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= RST_STATE;
      mem_req_r   <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_write_r <= mem_write_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
    end
  end

  // steer the completion pulse to the current owner only; a pulse
  // arriving in IDLE belongs to nobody and is dropped
  always_comb begin
    imem_ready_s = 1'b0;
    dmem_ready_s = 1'b0;
    if (bus.mem_ready_i) begin
      imem_ready_s = (state_r == ST_GNT_I);
      dmem_ready_s = (state_r == ST_GNT_D);
    end else begin
      imem_ready_s = 1'b0;
      dmem_ready_s = 1'b0;
    end
  end

  // return data is zero unless the matching ready is high
  always_comb begin
    bus.imem_rdata_o = '0;
    bus.dmem_rdata_o = '0;
    if (imem_ready_s) begin
      bus.imem_rdata_o = bus.mem_rdata_i;
    end else begin
      bus.imem_rdata_o = '0;
    end
    if (dmem_ready_s) begin
      bus.dmem_rdata_o = bus.mem_rdata_i;
    end else begin
      bus.dmem_rdata_o = '0;
    end
  end

  assign bus.imem_ready_o = imem_ready_s;
  assign bus.dmem_ready_o = dmem_ready_s;
  assign bus.mem_req_o    = mem_req_r;
  assign bus.mem_write_o  = mem_write_r;
  assign bus.mem_addr_o   = mem_addr_r;
  assign bus.mem_wdata_o  = mem_wdata_r;

`ifdef MEM_ARB_STATS_EN
  localparam logic [StatWidth-1:0] StatOne = StatWidth'(1);

  logic [StatWidth-1:0] igrant_r;
  logic [StatWidth-1:0] dgrant_r;
  logic [StatWidth-1:0] conflict_r;
  logic                 conflict_s;

  // a cycle is contended when someone is left waiting for the port
  always_comb begin
    conflict_s = 1'b0;
    case (state_r)
      ST_IDLE:  conflict_s = bus.imem_req_i && bus.dmem_req_i;
      ST_GNT_I: conflict_s = bus.dmem_req_i;
      ST_GNT_D: conflict_s = bus.imem_req_i;
      default:  conflict_s = 1'b0;
    endcase
  end

  // free-running statistics, wrapping naturally at the counter width
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      igrant_r   <= '0;
      dgrant_r   <= '0;
      conflict_r <= '0;
    end else begin
      if (grant_stb_s && (pick_s == GRANT_I)) begin
        igrant_r <= igrant_r + StatOne;
      end
      if (grant_stb_s && (pick_s == GRANT_D)) begin
        dgrant_r <= dgrant_r + StatOne;
      end
      if (conflict_s) begin
        conflict_r <= conflict_r + StatOne;
      end
    end
  end

  assign stat_igrant_o   = igrant_r;
  assign stat_dgrant_o   = dgrant_r;
  assign stat_conflict_o = conflict_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench. Requester processes replay
// per-port access queues, a behavioural memory answers with a set wait,
// and every ready pulse is matched against the expected port/data queue.
module tb_mem_port_arbiter;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DWidth(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_igrant;
  logic [31:0] stat_dgrant;
  logic [31:0] stat_conflict;
`endif

  mem_port_arbiter #(.DWidth(DW), .StatWidth(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
`ifdef MEM_ARB_STATS_EN
    .stat_igrant_o   (stat_igrant),
    .stat_dgrant_o   (stat_dgrant),
    .stat_conflict_o (stat_conflict),
`endif
    .bus             (bus.slave)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;

  req_t        iq[$];
  req_t        dq[$];
  exp_t        sb[$];
  logic [31:0] mem_model [int unsigned];
  int          mem_wait    = 0;
  bit          spurious    = 1'b0;
  int          n_vec       = 0;
  int          n_err       = 0;
  int          i_pulses    = 0;
  int          d_pulses    = 0;
  int          conf_cycles = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  // fetch requester: present the head of iq until its ready is seen
  initial begin
    bus.imem_req_i  = 1'b0;
    bus.imem_addr_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (iq.size() > 0) begin
        bus.imem_req_i  = 1'b1;
        bus.imem_addr_i = iq[0].addr;
      end else begin
        bus.imem_req_i  = 1'b0;
        bus.imem_addr_i = 32'h0;
      end
      @(negedge clk);
      if (bus.imem_ready_o && iq.size() > 0) void'(iq.pop_front());
    end
  end

  // data requester: same protocol on the dmem side
  initial begin
    bus.dmem_req_i   = 1'b0;
    bus.dmem_write_i = 1'b0;
    bus.dmem_addr_i  = 32'h0;
    bus.dmem_wdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (dq.size() > 0) begin
        bus.dmem_req_i   = 1'b1;
        bus.dmem_write_i = dq[0].write;
        bus.dmem_addr_i  = dq[0].addr;
        bus.dmem_wdata_i = dq[0].wdata;
      end else begin
        bus.dmem_req_i   = 1'b0;
        bus.dmem_write_i = 1'b0;
        bus.dmem_addr_i  = 32'h0;
        bus.dmem_wdata_i = 32'h0;
      end
      @(negedge clk);
      if (bus.dmem_ready_o && dq.size() > 0) void'(dq.pop_front());
    end
  end

  // memory: answer mem_req_o after mem_wait extra cycles, reset with rst
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ready_i = 1'b0;
      bus.mem_rdata_i = 32'h0;
      if (rst) begin
        cnt = 0;
      end else if (spurious) begin
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 32'hFFFF_FFFF;
        spurious = 1'b0;
      end else if (bus.mem_req_o) begin
        if (cnt == mem_wait) begin
          bus.mem_ready_i = 1'b1;
          if (bus.mem_write_o) mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
          else bus.mem_rdata_i = mem_read(bus.mem_addr_o);
        end
        cnt++;
      end else begin
        cnt = 0;
      end
    end
  end

  // count cycles in which both requesters are asserting
  initial begin
    forever begin
      @(posedge clk);
      if (rst) conf_cycles = 0;
      else if (bus.imem_req_i && bus.dmem_req_i) conf_cycles++;
    end
  end

  // scoreboard: every ready pulse must match the next expected completion
  initial begin
    exp_t e;
    logic        act_d;
    logic [31:0] act_rd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.imem_ready_o) i_pulses++;
        if (bus.dmem_ready_o) d_pulses++;
        if (bus.imem_ready_o || bus.dmem_ready_o) begin
          n_vec++;
          if (bus.imem_ready_o && bus.dmem_ready_o) begin
            n_err++;
            $display("FAIL one_ready: imem_ready=1 dmem_ready=1 at %0t, required at most one", $time);
          end else if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_ready: imem=%0b dmem=%0b at %0t, required none", bus.imem_ready_o, bus.dmem_ready_o, $time);
          end else begin
            e = sb.pop_front();
            act_d  = bus.dmem_ready_o;
            act_rd = act_d ? bus.dmem_rdata_o : bus.imem_rdata_o;
            if (act_d !== e.is_data || act_rd !== e.rdata) begin
              n_err++;
              $display("FAIL completion: port=%s rdata=%h, required port=%s rdata=%h at %0t",
                       act_d ? "D" : "I", act_rd, e.is_data ? "D" : "I", e.rdata, $time);
            end
          end
        end
        if (bus.mem_ready_i) begin
          n_vec++;
          if ((!bus.imem_ready_o && bus.imem_rdata_o !== 32'h0) ||
              (!bus.dmem_ready_o && bus.dmem_rdata_o !== 32'h0)) begin
            n_err++;
            $display("FAIL rdata_gate: imem_rdata=%h dmem_rdata=%h with ready low, required 0", bus.imem_rdata_o, bus.dmem_rdata_o);
          end
        end
      end
    end
  end

  // wait until all queued work has drained and the port is idle
  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while ((iq.size() != 0 || dq.size() != 0 || sb.size() != 0 || bus.mem_req_o) && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_vec++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: iq=%0d dq=%0d sb=%0d outstanding after %0d cycles, required 0", tag, iq.size(), dq.size(), sb.size(), k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.mem_req_o, bus.mem_write_o, bus.imem_ready_o, bus.dmem_ready_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctrl: req/write/iready/dready=%b, required 0000",
               {bus.mem_req_o, bus.mem_write_o, bus.imem_ready_o, bus.dmem_ready_o});
    end
    n_vec++;
    if (bus.mem_addr_o !== 32'h0 || bus.mem_wdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h wdata=%h, required 0 0", bus.mem_addr_o, bus.mem_wdata_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    int d0;
    bit seen;
    d0 = d_pulses;
    mem_wait = 3;
    dq.push_back('{1'b1, 32'h0000_1000, 32'hDEAD_BEEF});
    sb.push_back('{1'b1, 32'h0});
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (bus.dmem_ready_o) seen = 1'b1;
      if (bus.mem_req_o) begin
        n_vec++;
        if (bus.mem_write_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_1000 || bus.mem_wdata_o !== 32'hDEAD_BEEF) begin
          n_err++;
          $display("FAIL store_hold: write=%b addr=%h wdata=%h, required 1 00001000 deadbeef", bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
      end
    end
    wait_done(20, "store");
    n_vec++;
    if (d_pulses - d0 !== 1) begin
      n_err++;
      $display("FAIL store_pulses: %0d dmem_ready pulses, required 1", d_pulses - d0);
    end
  endtask

  task automatic test_fetch();
    int d0;
    d0 = d_pulses;
    mem_wait = 1;
    iq.push_back('{1'b0, 32'h0000_0010, 32'h0});
    sb.push_back('{1'b0, 32'h0051_3093});
    @(negedge clk);
    n_vec++;
    if (bus.mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_c0: mem_req=%b, required 0", bus.mem_req_o);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.mem_req_o, bus.mem_write_o, bus.imem_ready_o} !== 3'b100 ||
        bus.mem_addr_o !== 32'h10 || bus.mem_wdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL fetch_c1: req/write/iready=%b addr=%h wdata=%h, required 100 00000010 00000000",
               {bus.mem_req_o, bus.mem_write_o, bus.imem_ready_o}, bus.mem_addr_o, bus.mem_wdata_o);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.mem_req_o, bus.imem_ready_o, bus.dmem_ready_o} !== 3'b110) begin
      n_err++;
      $display("FAIL fetch_c2: req/iready/dready=%b, required 110", {bus.mem_req_o, bus.imem_ready_o, bus.dmem_ready_o});
    end
    @(negedge clk);
    n_vec++;
    if (bus.mem_req_o !== 1'b0 || bus.imem_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_c3: req=%b iready=%b, required 0 0", bus.mem_req_o, bus.imem_ready_o);
    end
    wait_done(10, "fetch");
    n_vec++;
    if (d_pulses !== d0) begin
      n_err++;
      $display("FAIL fetch_dquiet: %0d dmem_ready pulses, required 0", d_pulses - d0);
    end
  endtask

  task automatic test_readback();
    mem_wait = 0;
    dq.push_back('{1'b0, 32'h0000_1000, 32'h0});
    sb.push_back('{1'b1, 32'hDEAD_BEEF});
    wait_done(10, "readback");
  endtask

  task automatic test_contention(input int n);
    @(negedge clk);
    rst = 1'b1;
    mem_wait = 0;
    for (int k = 0; k < n; k++) begin
      iq.push_back('{1'b0, 32'h2000 + 32'(4 * k), 32'h0});
      dq.push_back('{1'b0, 32'h3000 + 32'(4 * k), 32'h0});
      sb.push_back('{1'b0, mem_read(32'h2000 + 32'(4 * k))});
      sb.push_back('{1'b1, mem_read(32'h3000 + 32'(4 * k))});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_done(10 * n + 10, "contention");
  endtask

  task automatic test_addr_hold();
    bit granted;
    mem_wait = 5;
    dq.push_back('{1'b0, 32'h0000_0100, 32'h0});
    sb.push_back('{1'b1, mem_read(32'h0000_0100)});
    granted = 1'b0;
    for (int k = 0; k < 6 && !granted; k++) begin
      @(negedge clk);
      if (bus.mem_req_o) granted = 1'b1;
    end
    n_vec++;
    if (!granted) begin
      n_err++;
      $display("FAIL hold_grant: mem_req=%b after 6 cycles, required 1", bus.mem_req_o);
    end
    dq[0].addr  = 32'h0000_0200;
    dq[0].wdata = 32'h1234_5678;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_vec++;
      if (bus.mem_addr_o !== 32'h100 || bus.mem_req_o !== 1'b1 || bus.dmem_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL hold_addr%0d: addr=%h req=%b dready=%b, required 00000100 1 0", k, bus.mem_addr_o, bus.mem_req_o, bus.dmem_ready_o);
      end
    end
    wait_done(15, "hold");
  endtask

  task automatic test_reset_mid();
    int i0;
    int d0;
    bit granted;
    i0 = i_pulses;
    d0 = d_pulses;
    mem_wait = 50;
    // a fetch first, so without a reset the next tie would go to data
    iq.push_back('{1'b0, 32'h0000_0040, 32'h0});
    sb.push_back('{1'b0, mem_read(32'h0000_0040)});
    granted = 1'b0;
    for (int k = 0; k < 6 && !granted; k++) begin
      @(negedge clk);
      if (bus.mem_req_o) granted = 1'b1;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mem_wait = 0;
    dq.push_back('{1'b0, 32'h0000_0080, 32'h0});
    sb.push_back('{1'b1, mem_read(32'h0000_0080)});
    @(negedge clk);
    n_vec++;
    if (!granted || bus.mem_req_o !== 1'b0 || bus.imem_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_abort: granted=%b req=%b iready=%b, required 1 0 0", granted, bus.mem_req_o, bus.imem_ready_o);
    end
    rst = 1'b0;
    wait_done(20, "rstmid");
    n_vec++;
    if (i_pulses - i0 !== 1 || d_pulses - d0 !== 1) begin
      n_err++;
      $display("FAIL rstmid_pulses: i=%0d d=%0d, required 1 1", i_pulses - i0, d_pulses - d0);
    end
  endtask

  task automatic test_idle_ready();
    @(negedge clk);
    spurious = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.mem_ready_i, bus.imem_ready_o, bus.dmem_ready_o, bus.mem_req_o} !== 4'b1000 ||
        bus.imem_rdata_o !== 32'h0 || bus.dmem_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL idle_ready: mready/iready/dready/req=%b irdata=%h drdata=%h, required 1000 0 0",
               {bus.mem_ready_i, bus.imem_ready_o, bus.dmem_ready_o, bus.mem_req_o}, bus.imem_rdata_o, bus.dmem_rdata_o);
    end
    @(negedge clk);
    n_vec++;
    if (bus.mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_noreq: mem_req=%b, required 0", bus.mem_req_o);
    end
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    test_contention(4);
    n_vec++;
    if (stat_igrant !== 32'd4 || stat_dgrant !== 32'd4) begin
      n_err++;
      $display("FAIL stat_grants: igrant=%0d dgrant=%0d, required 4 4", stat_igrant, stat_dgrant);
    end
    n_vec++;
    if (stat_conflict !== 32'(conf_cycles)) begin
      n_err++;
      $display("FAIL stat_conflict: %0d, required %0d", stat_conflict, conf_cycles);
    end
  endtask
`endif

  initial begin
    mem_model[32'h0000_0010] = 32'h0051_3093;
    test_reset();
    test_store();
    test_fetch();
    test_readback();
    test_contention(3);
    test_addr_hold();
    test_reset_mid();
    test_idle_ready();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard stop if anything above hangs
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the scalar core's instruction-fetch interface and its data interface.
- Sits between the core's imem/dmem request ports and the memory macro.
- Latches the granted request, drives the memory port until the memory signals completion, then routes the response back to the granted requester.
- Arbitration is two-way round-robin, so neither fetch nor load/store can starve the other.

Parameters:
- DWidth, 32, width of addresses and data on all interfaces.
- StatWidth, 32, width of each statistics counter (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- imem_req_i  in  1  instruction read request; held until imem_ready_o.
- imem_addr_i  in  DWidth  instruction address.
- imem_ready_o  out  1  one-cycle completion pulse to the fetch requester.
- imem_rdata_o  out  DWidth  instruction data; valid while imem_ready_o=1.
- dmem_req_i  in  1  data request; held until dmem_ready_o.
- dmem_write_i  in  1  1 = store, 0 = load.
- dmem_addr_i  in  DWidth  data address.
- dmem_wdata_i  in  DWidth  store data.
- dmem_ready_o  out  1  one-cycle completion pulse to the data requester.
- dmem_rdata_o  out  DWidth  load data; valid while dmem_ready_o=1.
- mem_req_o  out  1  request to memory; held until mem_ready_i.
- mem_write_o  out  1  write enable to memory.
- mem_addr_o  out  DWidth  memory address.
- mem_wdata_o  out  DWidth  memory write data.
- mem_ready_i  in  1  memory completion pulse.
- mem_rdata_i  in  DWidth  memory read data; valid with mem_ready_i.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - State = IDLE; last_grant = DATA, so fetch wins the first tie.
  - mem_req_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - imem_ready_o = 0, dmem_ready_o = 0.
- States:
  - IDLE: no request outstanding.
  - GNT_I: serving a fetch.
  - GNT_D: serving a load/store.
- IDLE transitions:
  - Only imem_req_i: go to GNT_I.
  - Only dmem_req_i: go to GNT_D.
  - Both: grant the port that is not last_grant.
  - Update last_grant at the grant edge.
  - Register addr/wdata/write from the granted port into the mem_* output registers. For a fetch, mem_write_o=0 and mem_wdata_o=0.
  - mem_req_o=1 from the cycle after grant.
- GNT_x:
  - Hold mem_req_o and all mem_* outputs stable.
  - On mem_ready_i=1: the granted port's ready_o=1 in the same cycle (combinational). rdata_o is passed through from mem_rdata_i. Next state is IDLE and mem_req_o=0 from the next cycle.
  - Changes on the requester's inputs after grant are ignored.
- rdata outputs:
  - imem_rdata_o and dmem_rdata_o are mem_rdata_i gated by the respective ready.
  - Both are 0 when that ready is low.
- mem_ready_i in IDLE: ignored; no ready_o pulse.
- Latency and throughput:
  - Request at cycle 0 in IDLE gives mem_req_o at cycle 1.
  - With a zero-wait memory, ready_o at cycle 1.
  - Minimum 2 cycles per transaction.
- Back-to-back: a requester still asserting req in the IDLE cycle after its ready is treated as a new request. Requesters drop req after ready or present the next access.
- Fairness: under continuous contention, grants strictly alternate I, D, I, D, …
- Reset mid-transaction: state returns to IDLE and mem_req_o=0 at the reset edge, with no ready_o pulse. The memory is reset on the same rst_i.
- Never more than one ready_o high in any cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, three StatWidth counters are added, with output ports stat_igrant_o, stat_dgrant_o and stat_conflict_o:
  - igrant: fetch grants.
  - dgrant: data grants.
  - conflict: cycles where both req are high and a requester is waiting (in IDLE with both requests, or in GNT_x with the other port's req high).
- Counter rules: wrap at 2^StatWidth; cleared by rst_i.
- When undefined, these ports and this logic are absent; arbitration behaviour is identical.

Decomposition:
- Package mem_arb_pkg contains:
  - typedef enum arb_state_e {IDLE, GNT_I, GNT_D}.
  - typedef enum grant_e {GRANT_I, GRANT_D}.
  - Localparam reset constants.
- Sub-module rr_arb2: two-request round-robin picker holding last_grant. It is combinational pick plus one register, updated on a grant strobe.
- The top module holds the FSM, the output registers and the optional counters.

Test Plan:
- Fetch only, addr 0x0000_0010, memory ready one cycle after mem_req_o, rdata 0x0051_3093 -> mem_req_o high cycles 1-2, mem_write_o=0, imem_ready_o pulse cycle 2 with imem_rdata_o 0x0051_3093, dmem_ready_o stays 0.
- Store only, addr 0x0000_1000, wdata 0xDEAD_BEEF -> mem_write_o=1, mem_addr_o 0x0000_1000, mem_wdata_o 0xDEAD_BEEF held stable until mem_ready_i; single dmem_ready_o pulse.
- Both req asserted out of reset, and continuously thereafter, for 6 transactions -> grant order I,D,I,D,I,D; never two ready_o in the same cycle.
- dmem_addr_i changed from 0x100 to 0x200 while GNT_D with memory stalled 5 cycles -> mem_addr_o stays 0x100 for all 5 cycles.
- rst_i asserted during GNT_I with memory stalled -> next cycle mem_req_o=0, state IDLE, no imem_ready_o pulse; a later fetch is granted normally with fetch priority restored.
- With MEM_ARB_STATS_EN: contention run of 4 I + 4 D -> stat_igrant_o=4, stat_dgrant_o=4, stat_conflict_o equals the bench-counted contention cycles.
